regdst_pipe_ctrl: RTL and testbench
===================================

// Module: regdst_pipe_ctrl
// PURPOSE
//  Sequences the 5-bit destination-register mux (bottom_mux) in the MIPS pipeline:
//  decodes the ID opcode into RegDst/RegWrite/MemRead and selects rd vs rt.
//  Carries the chosen destination through ID/EX -> EX/MEM -> MEM/WB.
//  Detects load-use hazards and raises a stall; accepts a branch flush.
// PARAMETERS
//  REG_W  5  register-index width (mux data width)
//  OP_W   6  opcode width
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous reset, active low
//  id_valid     in   1      ID stage holds a real instruction
//  id_opcode    in   OP_W   opcode of ID instruction
//  id_rs        in   REG_W  rs field
//  id_rt        in   REG_W  rt field
//  id_rd        in   REG_W  rd field
//  flush        in   1      squash the ID instruction (taken branch)
//  regdst_sel   out  1      combinational mux select: 1 = rd (mux a), 0 = rt (mux b)
//  stall        out  1      combinational: hold PC and IF/ID this cycle
//  ex_dest      out  REG_W  ID/EX destination
//  ex_regwrite  out  1      ID/EX write enable
//  ex_memread   out  1      ID/EX load flag
//  mem_dest     out  REG_W  EX/MEM destination
//  mem_regwrite out  1      EX/MEM write enable
//  wb_dest      out  REG_W  MEM/WB destination
//  wb_regwrite  out  1      MEM/WB write enable
// BEHAVIOUR
//  - Reset (rst_n=0, async): all registered outputs = 0. Mid-operation reset
//    clears every stage at once; no partial state survives.
//  - Decode (combinational): 000000 R-type: sel=1, wr=1, rd=0, uses_rt=1
//    100011 lw: sel=0, wr=1, memread=1, uses_rt=0 | 001000 addi: sel=0, wr=1, uses_rt=0
//    101011 sw, 000100 beq: sel=0, wr=0, uses_rt=1 | other: sel=0, wr=0, uses_rt=0.
//  - dest = regdst_sel ? id_rd : id_rt. regwrite is forced to 0 when dest == 0.
//  - stall = id_valid & ex_memread & (ex_dest != 0) &
//    (ex_dest == id_rs | (uses_rt & ex_dest == id_rt)).
//  - Each edge: the ID/EX load is a bubble (dest=0, wr=0, memread=0) if flush | stall |
//    !id_valid; otherwise it takes the decoded values. EX/MEM <= ID/EX and
//    MEM/WB <= EX/MEM always advance (the stall does not freeze the later stages).
//  - flush has priority over stall. Stall is forced low while flush=1.
//  - Latency: instruction in ID at edge k -> ex_* after k, mem_* after k+1, wb_* after k+2.
//  - Stall lasts exactly one cycle per load-use pair: the bubble clears ex_memread.
//  - Back-to-back loads to the same register: only the ID/EX occupant is checked.
//    Later stages are handled by forwarding, outside this block.
// STRUCTURE
//  - Shared package/header: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI localparams.
//    The REG_W and OP_W defaults also live there.
//  - Sub-module: bottom_mux instance (a=id_rd, b=id_rt, sel=regdst_sel).
//  - Remaining logic: decode, hazard compare, and three pipeline registers, all in
//    this module.
// TESTING
//  1 Reset: rst_n=0 mid-stream with wr set in all stages -> all outputs 0 immediately
//    (before the next edge).
//  2 R-type: op=000000 rt=5'h02 rd=5'h0A -> regdst_sel=1.
//    ex_dest=0A/wr=1, then mem_dest=0A, then wb_dest=0A.
//  3 addi: op=001000 rt=5'h03 rd=5'h1F -> regdst_sel=0, ex_dest=03, wr=1.
//    Same fields with rt=0 -> ex_regwrite=0.
//  4 Load-use: lw rt=5'h04, then R-type rs=04 -> stall=1 for one cycle.
//    The bubble gives ex_regwrite=0; next cycle stall=0 and ex_dest=R-type rd.
//  5 No false stall: lw rt=04, then addi rs=01 rt=04 -> stall=0.
//    lw rt=0, then R-type rs=0 -> stall=0.
//  6 Flush and stall together: lw rt=04, then R-type rs=04 with flush=1 -> stall=0.
//    ex_* = bubble; lw still reaches mem_dest=04, mem_regwrite=1.

Source files
------------

// File: rtl/regdst_pipe_ctrl_pkg.sv
// rtl/regdst_pipe_ctrl_pkg.sv - shared opcodes, widths and decode helper for regdst_pipe_ctrl
package regdst_pipe_ctrl_pkg;

  localparam int REG_W_DEF = 5;
  localparam int OP_W_DEF  = 6;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Control bits derived from the ID opcode
  typedef struct packed {
    logic sel;      // 1 = destination is rd, 0 = rt
    logic wr;       // instruction writes the register file
    logic memread;  // instruction is a load
    logic uses_rt;  // rt is a source operand (hazard compare must include it)
  } dec_t;

  function automatic dec_t decode_op(input logic [5:0] op);
    dec_t d;
    d = '0;
    case (op)
      OP_RTYPE: begin d.sel = 1'b1; d.wr = 1'b1; d.uses_rt = 1'b1; end
      OP_LW:    begin d.wr = 1'b1; d.memread = 1'b1; end
      OP_ADDI:  begin d.wr = 1'b1; end
      OP_SW,
      OP_BEQ:   begin d.uses_rt = 1'b1; end
      default:  d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/regdst_pipe_ctrl_bottom_mux.sv
// rtl/regdst_pipe_ctrl_bottom_mux.sv - 2:1 destination-register mux (a when sel=1, else b)
module bottom_mux #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] y
);

  assign y = sel ? a : b;

endmodule

// File: rtl/regdst_pipe_ctrl.sv
// rtl/regdst_pipe_ctrl.sv - destination-register decode, load-use stall and ID/EX..MEM/WB dest pipeline
module regdst_pipe_ctrl
  import regdst_pipe_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int OP_W  = OP_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [OP_W-1:0]  id_opcode,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             flush,
  output logic             regdst_sel,
  output logic             stall,
  output logic [REG_W-1:0] ex_dest,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic [REG_W-1:0] mem_dest,
  output logic             mem_regwrite,
  output logic [REG_W-1:0] wb_dest,
  output logic             wb_regwrite
);

  dec_t             w_dec;
  logic [REG_W-1:0] w_dest;
  logic             w_regwrite;
  logic             w_hit;
  logic             w_bubble;

  logic [REG_W-1:0] r_ex_dest;
  logic             r_ex_regwrite;
  logic             r_ex_memread;
  logic [REG_W-1:0] r_mem_dest;
  logic             r_mem_regwrite;
  logic [REG_W-1:0] r_wb_dest;
  logic             r_wb_regwrite;

  assign w_dec      = decode_op(6'(id_opcode));
  assign regdst_sel = w_dec.sel;

  bottom_mux #(.W(REG_W)) u_bottom_mux (
    .a   (id_rd),
    .b   (id_rt),
    .sel (regdst_sel),
    .y   (w_dest)
  );

  // Writes to r0 are architecturally discarded, so never flag them as writes
  assign w_regwrite = w_dec.wr & (w_dest != '0);

  // Only the ID/EX occupant is compared; older loads are covered by forwarding
  assign w_hit = (r_ex_dest == id_rs) | (w_dec.uses_rt & (r_ex_dest == id_rt));
  // A flushed ID instruction is being discarded anyway, so it never stalls
  assign stall = id_valid & ~flush & r_ex_memread & (r_ex_dest != '0) & w_hit;

  assign w_bubble = flush | stall | ~id_valid;

  // Three pipeline stages; later stages keep advancing while ID/EX takes a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_dest      <= '0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_mem_dest     <= '0;
      r_mem_regwrite <= 1'b0;
      r_wb_dest      <= '0;
      r_wb_regwrite  <= 1'b0;
    end else begin
      if (w_bubble) begin
        r_ex_dest     <= '0;
        r_ex_regwrite <= 1'b0;
        r_ex_memread  <= 1'b0;
      end else begin
        r_ex_dest     <= w_dest;
        r_ex_regwrite <= w_regwrite;
        r_ex_memread  <= w_dec.memread;
      end
      r_mem_dest     <= r_ex_dest;
      r_mem_regwrite <= r_ex_regwrite;
      r_wb_dest      <= r_mem_dest;
      r_wb_regwrite  <= r_mem_regwrite;
    end
  end

  assign ex_dest      = r_ex_dest;
  assign ex_regwrite  = r_ex_regwrite;
  assign ex_memread   = r_ex_memread;
  assign mem_dest     = r_mem_dest;
  assign mem_regwrite = r_mem_regwrite;
  assign wb_dest      = r_wb_dest;
  assign wb_regwrite  = r_wb_regwrite;

endmodule

// File: tb/tb_regdst_pipe_ctrl.sv
// tb/tb_regdst_pipe_ctrl.sv - self-checking bench for regdst_pipe_ctrl
module tb_regdst_pipe_ctrl;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [5:0] id_opcode;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [4:0] id_rd;
  logic       flush;
  logic       regdst_sel;
  logic       stall;
  logic [4:0] ex_dest;
  logic       ex_regwrite;
  logic       ex_memread;
  logic [4:0] mem_dest;
  logic       mem_regwrite;
  logic [4:0] wb_dest;
  logic       wb_regwrite;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int dest;
    int wr;
    int mr;
  } stage_t;

  // pipe[0] = ID/EX, pipe[1] = EX/MEM, pipe[2] = MEM/WB
  stage_t pipe[3];

  regdst_pipe_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_opcode    (id_opcode),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rd        (id_rd),
    .flush        (flush),
    .regdst_sel   (regdst_sel),
    .stall        (stall),
    .ex_dest      (ex_dest),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .mem_dest     (mem_dest),
    .mem_regwrite (mem_regwrite),
    .wb_dest      (wb_dest),
    .wb_regwrite  (wb_regwrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0};
  endtask

  // Reference decode straight from the opcode table
  function automatic void ref_decode(input int op, output int sel, output int wr,
                                     output int mr, output int urt);
    sel = 0; wr = 0; mr = 0; urt = 0;
    if (op == 'h00)      begin sel = 1; wr = 1; urt = 1; end
    else if (op == 'h23) begin wr = 1; mr = 1; end
    else if (op == 'h08) begin wr = 1; end
    else if (op == 'h2B || op == 'h04) begin urt = 1; end
  endfunction

  task automatic drive(input int v, input int op, input int rs, input int rt,
                       input int rd, input int fl);
    id_valid  = 1'(v);
    id_opcode = 6'(op);
    id_rs     = 5'(rs);
    id_rt     = 5'(rt);
    id_rd     = 5'(rd);
    flush     = 1'(fl);
  endtask

  task automatic check_regs();
    check("ex_dest",      int'(ex_dest),      pipe[0].dest);
    check("ex_regwrite",  int'(ex_regwrite),  pipe[0].wr);
    check("ex_memread",   int'(ex_memread),   pipe[0].mr);
    check("mem_dest",     int'(mem_dest),     pipe[1].dest);
    check("mem_regwrite", int'(mem_regwrite), pipe[1].wr);
    check("wb_dest",      int'(wb_dest),      pipe[2].dest);
    check("wb_regwrite",  int'(wb_regwrite),  pipe[2].wr);
  endtask

  // Checks combinational outputs for the current inputs, clocks once, checks stages
  task automatic step();
    int sel, wr, mr, urt, dest, exp_stall;
    stage_t nx;
    #1;
    ref_decode(int'(id_opcode), sel, wr, mr, urt);
    dest = sel ? int'(id_rd) : int'(id_rt);
    exp_stall = 0;
    if (id_valid && !flush && pipe[0].mr == 1 && pipe[0].dest != 0 &&
        (pipe[0].dest == int'(id_rs) || (urt == 1 && pipe[0].dest == int'(id_rt))))
      exp_stall = 1;
    check("regdst_sel", int'(regdst_sel), sel);
    check("stall", int'(stall), exp_stall);
    if (!id_valid || flush || exp_stall == 1) nx = '{0, 0, 0};
    else nx = '{dest, (wr == 1 && dest != 0) ? 1 : 0, mr};
    @(posedge clk);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = nx;
    #1;
    check_regs();
  endtask

  initial begin
    int ops[6] = '{'h00, 'h23, 'h08, 'h2B, 'h04, 'h3F};
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_clear();
    #2;
    check_regs();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // R-type: rd selected, then walks through the stages
    drive(1, 'h00, 1, 'h02, 'h0A, 0);
    step();
    check("rtype_ex_dest", int'(ex_dest), 'h0A);
    check("rtype_ex_wr", int'(ex_regwrite), 1);
    drive(0, 0, 0, 0, 0, 0);
    step();
    check("rtype_mem_dest", int'(mem_dest), 'h0A);
    step();
    check("rtype_wb_dest", int'(wb_dest), 'h0A);

    // addi: rt selected; rt=0 suppresses the write
    drive(1, 'h08, 1, 'h03, 'h1F, 0);
    #1 check("addi_sel", int'(regdst_sel), 0);
    step();
    check("addi_ex_dest", int'(ex_dest), 'h03);
    check("addi_ex_wr", int'(ex_regwrite), 1);
    drive(1, 'h08, 1, 0, 'h1F, 0);
    step();
    check("addi_r0_wr", int'(ex_regwrite), 0);

    // Load-use: one-cycle stall, bubble, then the held instruction proceeds
    drive(1, 'h23, 1, 'h04, 0, 0);
    step();
    drive(1, 'h00, 'h04, 'h01, 'h07, 0);
    #1 check("lu_stall", int'(stall), 1);
    step();
    check("lu_bubble_wr", int'(ex_regwrite), 0);
    #1 check("lu_stall_clear", int'(stall), 0);
    step();
    check("lu_ex_dest", int'(ex_dest), 'h07);

    // No false stall
    drive(1, 'h23, 1, 'h04, 0, 0);
    step();
    drive(1, 'h08, 'h01, 'h04, 0, 0);
    #1 check("addi_no_stall", int'(stall), 0);
    step();
    drive(1, 'h23, 1, 0, 0, 0);
    step();
    drive(1, 'h00, 0, 'h01, 'h05, 0);
    #1 check("r0_no_stall", int'(stall), 0);
    step();

    // Flush beats stall; the load still advances
    drive(1, 'h23, 1, 'h04, 0, 0);
    step();
    drive(1, 'h00, 'h04, 'h01, 'h07, 1);
    #1 check("flush_no_stall", int'(stall), 0);
    step();
    check("flush_ex_wr", int'(ex_regwrite), 0);
    check("flush_ex_dest", int'(ex_dest), 0);
    check("flush_mem_dest", int'(mem_dest), 'h04);
    check("flush_mem_wr", int'(mem_regwrite), 1);

    // Randomized traffic with a small register pool to provoke hazards
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 7) != 0) ? 1 : 0, ops[$urandom_range(0, 5)],
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            ($urandom_range(0, 7) == 0) ? 1 : 0);
      step();
    end

    // Mid-stream async reset with writes in flight
    drive(1, 'h00, 1, 1, 'h11, 0);
    step();
    drive(1, 'h08, 1, 'h12, 0, 0);
    step();
    drive(1, 'h23, 1, 'h13, 0, 0);
    step();
    rst_n = 1'b0;
    model_clear();
    #1;
    check_regs();
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
